// File: rtl/serial_iter_comparator_pkg.sv
// Shared types for the serial iterative comparator.
//   state_t : FSM state encoding (IDLE, RUN, DONE), also exposed on the
//             top-level fsm_state debug port.
//   rel_t   : running A-vs-B relation accumulated chunk by chunk.
//   rel_from: folds one chunk's gt/lt flags into a relation, keeping
//             the supplied fallback when the chunk pair is equal.
package serial_iter_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  function automatic rel_t rel_from(input logic chunk_gt, input logic chunk_lt,
                                    input rel_t hold);
    rel_t r;
    if (chunk_gt)      r = REL_GT;
    else if (chunk_lt) r = REL_LT;
    else               r = hold;
    return r;
  endfunction

endpackage

// File: rtl/serial_iter_comparator_chunk.sv
// Combinational K-bit unsigned compare cell, built as the classic
// iterative bit-cell chain running from the LSB up to the MSB.
// Ports:
//   a, b : K-bit chunk operands
//   gt   : a > b
//   lt   : a < b
module serial_iter_comparator_chunk #(
  parameter int K = 1
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic         gt,
  output logic         lt
);

  // g_c[i] / l_c[i] hold the relation of bits [i-1:0]. A higher bit that
  // differs decides the relation; an equal bit passes the lower result up.
  logic [K:0] g_c;
  logic [K:0] l_c;

  always_comb begin
    g_c = '0;
    l_c = '0;
    for (int i = 0; i < K; i++) begin
      g_c[i+1] = (a[i] & ~b[i]) | ((a[i] ~^ b[i]) & g_c[i]);
      l_c[i+1] = (~a[i] & b[i]) | ((a[i] ~^ b[i]) & l_c[i]);
    end
  end

  assign gt = g_c[K];
  assign lt = l_c[K];

endmodule

// File: rtl/serial_iter_comparator.sv
// Serial unsigned comparator: compares two N-bit words K bits per clock.
// dir=0 walks LSB chunk first (later, more significant chunks override),
// dir=1 walks MSB chunk first (first differing chunk decides, with an
// optional early exit).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, dir, A, B: request, direction and operands (captured on accept)
//   busy            : high while a compare is running
//   done            : one-cycle pulse, result registers updated
//   zout, gt, eq    : A<=B, A>B, A==B; held until the next done
//   fsm_state       : current FSM state, for observation
//
// Handshake: start is sampled on any rising edge where the FSM is not in
// RUN (i.e. busy==0); that edge captures A, B and dir. While busy==1,
// start is ignored. done rises for exactly one cycle after the edge that
// finishes the compare, and zout/gt/eq change only on that same edge.
module serial_iter_comparator
  import serial_iter_comparator_pkg::*;
#(
  parameter int N          = 8,
  parameter int K          = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dir,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         zout,
  output logic         gt,
  output logic         eq,
  output state_t       fsm_state
);

  localparam int C  = N / K;
  localparam int CW = $clog2(C + 1);
  localparam logic [CW-1:0] LAST = CW'(C - 1);

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   sh_a;
  logic [N-1:0]   sh_b;
  logic           dir_q;
  logic [CW-1:0]  cnt;
  rel_t           rel;
  rel_t           rel_next;
  logic [K-1:0]   ch_a;
  logic [K-1:0]   ch_b;
  logic           ch_gt;
  logic           ch_lt;
  logic           accept;
  logic           finish;
  logic           last_chunk;
  logic           early;

  // The chunk under test always sits at the end of the shift register
  // that the current direction consumes from.
  assign ch_a = dir_q ? sh_a[N-1 -: K] : sh_a[K-1:0];
  assign ch_b = dir_q ? sh_b[N-1 -: K] : sh_b[K-1:0];

  serial_iter_comparator_chunk #(.K(K)) u_chunk (
    .a  (ch_a),
    .b  (ch_b),
    .gt (ch_gt),
    .lt (ch_lt)
  );

  // LSB-first: every chunk is more significant than the ones before, so a
  // differing chunk overrides. MSB-first: the first difference is final.
  always_comb begin
    rel_next = rel;
    if (dir_q) begin
      if (rel == REL_EQ) rel_next = rel_from(ch_gt, ch_lt, REL_EQ);
    end else begin
      rel_next = rel_from(ch_gt, ch_lt, rel);
    end
  end

  assign last_chunk = (cnt == LAST);
  assign early      = (EARLY_EXIT != 0) && dir_q && (ch_gt || ch_lt);
  assign accept     = start && (state != ST_RUN);
  assign finish     = (state == ST_RUN) && (last_chunk || early);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (finish) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand shift registers, chunk counter, relation and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      dir_q <= 1'b0;
      cnt   <= '0;
      rel   <= REL_EQ;
      zout  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
    end else if (accept) begin
      sh_a  <= A;
      sh_b  <= B;
      dir_q <= dir;
      cnt   <= '0;
      rel   <= REL_EQ;
    end else if (state == ST_RUN) begin
      sh_a <= dir_q ? (sh_a << K) : (sh_a >> K);
      sh_b <= dir_q ? (sh_b << K) : (sh_b >> K);
      cnt  <= cnt + CW'(1);
      rel  <= rel_next;
      if (finish) begin
        gt   <= (rel_next == REL_GT);
        eq   <= (rel_next == REL_EQ);
        zout <= (rel_next != REL_GT);
      end
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

endmodule
